// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch op encodings, mcause codes and the
// branch-resolve shadow FSM states.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLT  = 4'd3,
    OP_BGE  = 4'd4,
    OP_BLTU = 4'd5,
    OP_BGEU = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8
  } br_op_e;

  localparam logic [3:0] CAUSE_INS_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
  localparam logic [3:0] CAUSE_BREAK        = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } mb_state_e;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: op/rs1/rs2 -> taken.
// Unknown ops and NONE are never taken; JAL/JALR always are.
module branch_cmp
  import cpu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (rs1 == rs2);
      OP_BNE:  taken = (rs1 != rs2);
      OP_BLT:  taken = (rs1_s < rs2_s);
      OP_BGE:  taken = (rs1_s >= rs2_s);
      OP_BLTU: taken = (rs1 < rs2);
      OP_BGEU: taken = (rs1 >= rs2);
      OP_JAL:  taken = 1'b1;
      OP_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// MB-stage branch/jump/trap resolution with a wrong-path shadow FSM.
// Optional performance counters are enabled by defining MB_PERF_COUNT_EN.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0040,
  parameter int          SHADOW_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic        ex_mb__valid,
  input  logic [31:0] ex_mb__pc,
  input  logic [3:0]  ex_mb__op,
  input  logic [31:0] ex_mb__rs1,
  input  logic [31:0] ex_mb__rs2,
  input  logic [31:0] ex_mb__imm,
  input  logic        ex_mb__predict_taken,
  input  logic        ex_mb__trap,
  input  logic [3:0]  ex_mb__trap_cause,
  input  logic [31:0] mtvec,
  output logic [31:0] mb_if__jump_target,
  output logic        mb_if__branch_taken,
  output logic        mb_if__trap_taken,
  output logic        mb_if__predict_taken,
  output logic [31:0] mb_if__pc_4,
  output logic [31:0] mb_wb__link,
  output logic [31:0] trap_epc,
  output logic [3:0]  trap_cause,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam logic [2:0] SHADOW_INIT = 3'(SHADOW_DEPTH - 1);

  mb_state_e   state_q, state_d;
  logic [2:0]  shadow_cnt_q, shadow_cnt_d;
  logic [31:0] jump_target_q, jump_target_d;
  logic        branch_taken_q, branch_taken_d;
  logic        trap_taken_q, trap_taken_d;
  logic        predict_taken_q, predict_taken_d;
  logic [31:0] pc_4_q, pc_4_d;
  logic [31:0] link_q, link_d;
  logic [31:0] trap_epc_q, trap_epc_d;
  logic [3:0]  trap_cause_q, trap_cause_d;

  logic        cmp_taken;
  logic        live;
  logic        is_branch;
  logic        misalign;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  branch_cmp u_cmp (
    .op    (ex_mb__op),
    .rs1   (ex_mb__rs1),
    .rs2   (ex_mb__rs2),
    .taken (cmp_taken)
  );

  always_comb begin
    live      = ex_mb__valid && (state_q == ST_RUN) && !pipe_flush;
    is_branch = is_branch_op(ex_mb__op);
    pc_plus4  = ex_mb__pc + 32'd4;
    if (ex_mb__op == OP_JALR) target = (ex_mb__rs1 + ex_mb__imm) & ~32'h1;
    else                      target = ex_mb__pc + ex_mb__imm;
    misalign  = is_branch && cmp_taken && (target[1:0] != 2'b00);

    jump_target_d   = target;
    branch_taken_d  = 1'b0;
    trap_taken_d    = 1'b0;
    predict_taken_d = 1'b0;
    pc_4_d          = pc_plus4;
    link_d          = pc_plus4;
    trap_epc_d      = trap_epc_q;
    trap_cause_d    = trap_cause_q;
    redirect        = 1'b0;

    if (live) begin
      if (ex_mb__trap || misalign) begin
        trap_taken_d  = 1'b1;
        jump_target_d = mtvec & ~32'h3;
        trap_epc_d    = ex_mb__pc;
        trap_cause_d  = ex_mb__trap ? ex_mb__trap_cause : CAUSE_INS_MISALIGN;
      end else begin
        branch_taken_d  = is_branch && cmp_taken;
        predict_taken_d = is_branch && ex_mb__predict_taken;
      end
      redirect = trap_taken_d || (branch_taken_d != predict_taken_d);
    end

    // Shadow FSM: squash the wrong-path slots already in flight after a redirect
    state_d      = state_q;
    shadow_cnt_d = shadow_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          state_d      = ST_SHADOW;
          shadow_cnt_d = SHADOW_INIT;
        end
      end
      ST_SHADOW: begin
        if (shadow_cnt_q == 3'd0) state_d = ST_RUN;
        else                      shadow_cnt_d = shadow_cnt_q - 3'd1;
      end
      default: begin
        state_d      = ST_RUN;
        shadow_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      shadow_cnt_q    <= 3'd0;
      jump_target_q   <= 32'd0;
      branch_taken_q  <= 1'b0;
      trap_taken_q    <= 1'b0;
      predict_taken_q <= 1'b0;
      pc_4_q          <= RESET_VECTOR;
      link_q          <= RESET_VECTOR;
      trap_epc_q      <= RESET_VECTOR;
      trap_cause_q    <= 4'd0;
    end else begin
      state_q         <= state_d;
      shadow_cnt_q    <= shadow_cnt_d;
      jump_target_q   <= jump_target_d;
      branch_taken_q  <= branch_taken_d;
      trap_taken_q    <= trap_taken_d;
      predict_taken_q <= predict_taken_d;
      pc_4_q          <= pc_4_d;
      link_q          <= link_d;
      trap_epc_q      <= trap_epc_d;
      trap_cause_q    <= trap_cause_d;
    end
  end

`ifdef MB_PERF_COUNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (live && is_branch && !trap_taken_d) begin
      perf_branches_d = perf_branches_q + 32'd1;
      if (redirect) perf_mispredicts_d = perf_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches_q    <= 32'd0;
      perf_mispredicts_q <= 32'd0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`else
  assign perf_branches    = 32'd0;
  assign perf_mispredicts = 32'd0;
`endif

  assign mb_if__jump_target   = jump_target_q;
  assign mb_if__branch_taken  = branch_taken_q;
  assign mb_if__trap_taken    = trap_taken_q;
  assign mb_if__predict_taken = predict_taken_q;
  assign mb_if__pc_4          = pc_4_q;
  assign mb_wb__link          = link_q;
  assign trap_epc             = trap_epc_q;
  assign trap_cause           = trap_cause_q;

endmodule
